// File: rtl/framebuffer_ram.sv
// framebuffer_ram: simple dual-port pixel RAM with read pipeline and clear engine.
// Write port from loader/generator, read port from scan-out.
module framebuffer_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int READ_LATENCY = 1,
  parameter string INIT_FILE = "image.list",
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH-1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   cnt;
  logic                  last;
  logic                  clr_we;
  logic [DATA_WIDTH-1:0] d1;
  logic                  v1;

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (clear_req) state_n = CLEAR;
      CLEAR: if (last)      state_n = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = 1'b0;
    clr_we     = 1'b0;
    clear_busy = (state == CLEAR);
    clr_we     = clear_busy;
    wr_ready   = !clear_busy;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= (state == CLEAR) && last;
      if (state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // Clear and external writes never coincide: wr_ready is low while clearing.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[cnt[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
    else if (wr_en && wr_ready)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_en;
      if (rd_en) d1 <= mem[rd_addr];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] d2;
    logic                  v2;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        d2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign rd_data  = d2;
    assign rd_valid = v2;
  end else begin : g_lat1
    assign rd_data  = d1;
    assign rd_valid = v1;
  end

endmodule
